conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Parametrised successor to the fixed 16x16 tactile convolution stage.
- Applies a runtime-programmable signed 3x3 kernel to a raster-scanned sensor frame of ROWS switch wires x COLS read wires.
- Streams pixels in and out with valid/ready handshakes, supports backpressure and selectable edge handling, and saturates its output.
- Sits between the scan/ADC front end and the frame BRAM writer.

Parameters:
- ROWS, 16, switch-wire count (frame rows); >= 3
- COLS, 16, read-wire count (frame columns); >= 3
- DW, 12, unsigned pixel width, in and out
- CW, 8, signed coefficient width
- SHW, 5, shift-amount width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid && s_ready
- s_data  in  DW  unsigned pixel, raster order: row-major, column fastest
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  DW  filtered pixel
- m_row  out  $clog2(ROWS)  row index of m_data
- m_col  out  $clog2(COLS)  column index of m_data
- m_sof  out  1  high with output pixel (0,0)
- coeffs  in  9*CW  kernel; element k = bits [k*CW +: CW], k = 3*i + j; i = row offset -1..+1 maps to 0..2, j = column offset likewise
- shift  in  SHW  arithmetic right-shift amount
- edge_mode  in  1  0: border pixels pass through unfiltered; 1: border pixels output 0

Behaviour:
- Reset values: m_valid=0, m_data=0, m_row=0, m_col=0, m_sof=0. Input row/column counters and the primed flag clear.
- s_ready is 1 during reset deassertion.
- Line-buffer RAM is not reset. Stale contents never reach an output, because all row-0 outputs are border pixels.
- Pipeline enable: en = !m_valid || m_ready. s_ready = en, combinational. When en=0 the entire pipeline holds.
- Input counters (row, col) advance on each accepted sample:
  - col wraps COLS-1 -> 0 and increments row.
  - row wraps ROWS-1 -> 0, so frames are back-to-back with no gaps.
- Window formation:
  - Two COLS-deep line buffers plus a 3x3 window register.
  - The window for centre (r,c) is complete when the sample at raster index (r,c)+COLS+1 is accepted, modulo frame size.
  - The first COLS+1 accepted samples after reset produce no output. After that, each accepted sample produces exactly one output.
  - Output (ROWS-1, *) is produced from samples of the next frame.
- Output coordinates run their own raster counters, starting at (0,0) after priming.
- Border pixel: r==0, r==ROWS-1, c==0 or c==COLS-1. Its value is the centre sample or 0, per edge_mode.
- Arithmetic:
  - Each pixel is zero-extended to DW+1 bits signed, then multiplied by its signed coefficient.
  - Accumulator width is DW+CW+5 bits, signed; no overflow is possible.
  - sum >>> shift (arithmetic shift).
  - Saturate to [0, 2^DW-1]: negative results give 0, results > max give 2^DW-1.
- Latency: 3 enabled cycles. A sample accepted at edge k presents its output after edge k+3 with m_valid=1, provided en stays 1.
- Stages: S1 row partial sums; S2 total and shift; S3 saturate, border select and output register.
- Holding: while m_valid && !m_ready, m_data, m_row, m_col and m_sof are held stable.
- Config shadowing:
  - coeffs, shift and edge_mode are captured into shadow registers when the window for output centre (0,0) forms.
  - One output frame uses exactly one configuration. Mid-frame input changes take effect at the next output (0,0).
  - Before the first capture, shadows are 0.
- Reset mid-operation: all state returns to reset values immediately, in-flight pixels are discarded, and priming restarts. The upstream source must restart its frame at (0,0).

Optional Feature:
- Macro: CONV3X3_ROUND_EN
- Defined: when shift > 0, add 1 <<< (shift-1) to the sum before shifting (round half up, toward +inf), then saturate.
- Undefined: plain truncating arithmetic shift.
- Latency is unchanged in both cases.

Test Plan:
- Identity kernel (centre=1, others 0, shift=0), ROWS=COLS=4, input ramp 0..15 repeated -> first m_valid appears 3 cycles after the 6th accepted sample, with (0,0)=0 and m_sof=1. Outputs are 0..15 in order with matching m_row/m_col, and each frame repeats.
- All-ones kernel, shift=0, constant input 100 -> interior outputs 900. Border outputs are 100 with edge_mode=0 and 0 with edge_mode=1.
- Saturation: all-ones kernel, input 4095 -> interior 4095. Centre=-1, others 0, input 50 -> interior 0.
- Backpressure: m_ready low for 5 cycles mid-frame -> s_ready=0, and m_data/m_row/m_col stay stable for those 5 cycles. The full sequence afterwards has no drops or duplicates.
- Reset asserted mid-frame (output at (2,1)) -> m_valid drops asynchronously. After release and a restarted frame, the first output is (0,0) after COLS+1 samples.
- Config change: shift 0 -> 1 applied at output (1,2) -> the rest of that frame uses shift 0, and the next frame from (0,0) uses shift 1. With CONV3X3_ROUND_EN, interior sum 7 with shift 1 gives 4; without the macro it gives 3.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: pixel-in/pixel-out handshakes plus kernel configuration for conv3x3_stream.
interface conv3x3_stream_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int DW = 12,
  parameter int CW = 8,
  parameter int SHW = 5
);
  logic s_valid;
  logic s_ready;
  logic [DW-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [DW-1:0] m_data;
  logic [$clog2(ROWS)-1:0] m_row;
  logic [$clog2(COLS)-1:0] m_col;
  logic m_sof;
  logic [9*CW-1:0] coeffs;
  logic [SHW-1:0] shift;
  logic edge_mode;
  modport slave (
    input s_valid, s_data, m_ready, coeffs, shift, edge_mode,
    output s_ready, m_valid, m_data, m_row, m_col, m_sof
  );
  modport master (
    output s_valid, s_data, m_ready, coeffs, shift, edge_mode,
    input s_ready, m_valid, m_data, m_row, m_col, m_sof
  );
endinterface

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming signed 3x3 convolution with line buffers, backpressure and saturation.
// Define CONV3X3_ROUND_EN to round half up before the arithmetic right shift.
module conv3x3_stream #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int DW = 12,
  parameter int CW = 8,
  parameter int SHW = 5
) (
  input logic clk,
  input logic rst,
  conv3x3_stream_if.slave io
);
  localparam int RW = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int AW = DW + CW + 5;
  logic en, acc, fire, primed;
  logic [RW-1:0] in_r, out_r, r0, r1, r2;
  logic [CLW-1:0] in_c, out_c, c0, c1, c2;
  logic [DW-1:0] lb0 [COLS];
  logic [DW-1:0] lb1 [COLS];
  logic [DW-1:0] w [3][3];
  logic [DW-1:0] cen1, cen2, sat;
  logic [9*CW-1:0] coef_sh;
  logic [SHW-1:0] shift_sh, sh1;
  logic em_sh, em1, em2, v0, v1, v2, b0, b1, b2;
  logic signed [AW-1:0] rs [3];
  logic signed [AW-1:0] rs1 [3];
  logic signed [AW-1:0] rnd, sum2;
  assign en = !io.m_valid || io.m_ready;
  assign io.s_ready = en;
  assign acc = io.s_valid && en;
  assign fire = acc && primed;
  always_comb
    for (int i = 0; i < 3; i++) begin
      rs[i] = '0;
      for (int j = 0; j < 3; j++)
        rs[i] = rs[i] + AW'($signed({1'b0, w[i][j]})) * AW'($signed(coef_sh[(3*i+j)*CW +: CW]));
    end
`ifdef CONV3X3_ROUND_EN
  assign rnd = sh1 != '0 ? AW'(1) <<< (sh1 - 1'b1) : '0;
`else
  assign rnd = '0;
`endif
  assign sat = sum2[AW-1] ? '0 : |sum2[AW-2:DW] ? {DW{1'b1}} : sum2[DW-1:0];
  // Line buffers and window are never reset: row-0 outputs are all borders, so stale data is masked.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[in_c] <= io.s_data;
      lb1[in_c] <= lb0[in_c];
      for (int i = 0; i < 3; i++) begin
        w[i][0] <= w[i][1];
        w[i][1] <= w[i][2];
      end
      w[0][2] <= lb1[in_c];
      w[1][2] <= lb0[in_c];
      w[2][2] <= io.s_data;
    end
    if (fire) begin
      r0 <= out_r;
      c0 <= out_c;
      b0 <= out_r == '0 || out_r == RW'(ROWS-1) || out_c == '0 || out_c == CLW'(COLS-1);
    end
    if (en) begin
      rs1 <= rs;
      sh1 <= shift_sh;
      em1 <= em_sh;
      b1 <= b0;
      cen1 <= w[1][1];
      r1 <= r0;
      c1 <= c0;
      sum2 <= (rs1[0] + rs1[1] + rs1[2] + rnd) >>> sh1;
      em2 <= em1;
      b2 <= b1;
      cen2 <= cen1;
      r2 <= r1;
      c2 <= c1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_r <= '0;
      in_c <= '0;
      out_r <= '0;
      out_c <= '0;
      primed <= 1'b0;
      coef_sh <= '0;
      shift_sh <= '0;
      em_sh <= 1'b0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      io.m_valid <= 1'b0;
      io.m_data <= '0;
      io.m_row <= '0;
      io.m_col <= '0;
      io.m_sof <= 1'b0;
    end else begin
      if (acc) begin
        in_c <= in_c == CLW'(COLS-1) ? '0 : in_c + 1'b1;
        if (in_c == CLW'(COLS-1)) in_r <= in_r == RW'(ROWS-1) ? '0 : in_r + 1'b1;
        if (in_r == RW'(1) && in_c == '0) primed <= 1'b1;
      end
      // Config is latched as the (0,0) window forms so a whole output frame shares one setting.
      if (fire) begin
        out_c <= out_c == CLW'(COLS-1) ? '0 : out_c + 1'b1;
        if (out_c == CLW'(COLS-1)) out_r <= out_r == RW'(ROWS-1) ? '0 : out_r + 1'b1;
        if (out_r == '0 && out_c == '0) begin
          coef_sh <= io.coeffs;
          shift_sh <= io.shift;
          em_sh <= io.edge_mode;
        end
      end
      if (en) begin
        v0 <= fire;
        v1 <= v0;
        v2 <= v1;
        io.m_valid <= v2;
        io.m_data <= b2 ? (em2 ? '0 : cen2) : sat;
        io.m_row <= r2;
        io.m_col <= c2;
        io.m_sof <= r2 == '0 && c2 == '0;
      end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: randomized self-checking bench against a frame-history reference model.
`timescale 1ns/1ps
module tb_conv3x3_stream;
  localparam int ROWS = 4, COLS = 4, DW = 12, CW = 8, SHW = 5;
  localparam int RW = $clog2(ROWS), CLW = $clog2(COLS), FS = ROWS * COLS;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic [CLW-1:0] c;
    logic sof;
  } pix_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  conv3x3_stream_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .CW(CW), .SHW(SHW)) io ();
  conv3x3_stream #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .CW(CW), .SHW(SHW)) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );
  always #5 clk = ~clk;

  pix_t exp_q[$];
  pix_t got_q[$];
  int hist[$];
  int nacc;
  int n_checks = 0;
  int n_fail = 0;
  logic [9*CW-1:0] m_coef;
  int m_sh;
  bit m_em;

  // Reference: output for centre g is taken straight from the accepted-sample history.
  task automatic model_accept(input int v);
    int g, r, c, s;
    pix_t p;
    hist.push_back(v);
    nacc++;
    if (nacc < COLS + 2) return;
    g = nacc - COLS - 2;
    r = (g / COLS) % ROWS;
    c = g % COLS;
    if (r == 0 && c == 0) begin
      m_coef = io.coeffs;
      m_sh = int'(io.shift);
      m_em = io.edge_mode;
    end
    if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) s = m_em ? 0 : hist[g];
    else begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += hist[g + (i - 1) * COLS + (j - 1)] * int'($signed(m_coef[(3*i+j)*CW +: CW]));
`ifdef CONV3X3_ROUND_EN
      if (m_sh > 0) s += 1 <<< (m_sh - 1);
`endif
      s = s >>> m_sh;
      s = s < 0 ? 0 : (s > 4095 ? 4095 : s);
    end
    p.d = DW'(s);
    p.r = RW'(r);
    p.c = CLW'(c);
    p.sof = r == 0 && c == 0;
    exp_q.push_back(p);
  endtask

  task automatic step(input bit sv, input int sd, input bit mr, output bit a);
    pix_t p;
    io.s_valid = sv;
    io.s_data = DW'(sd);
    io.m_ready = mr;
    @(negedge clk);
    a = io.s_valid && io.s_ready;
    if (a) model_accept(sd);
    if (io.m_valid && io.m_ready) begin
      p = {io.m_data, io.m_row, io.m_col, io.m_sof};
      got_q.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    hist.delete();
    exp_q.delete();
    got_q.delete();
    nacc = 0;
    m_coef = '0;
    m_sh = 0;
    m_em = 1'b0;
  endtask

  task automatic do_reset();
    io.s_valid = 1'b0;
    io.m_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic run(input int n, input int kind, input int val, input int pv, input int pr);
    bit a;
    int v;
    for (int i = 0; i < n; i++) begin
      v = kind == 0 ? i % FS : (kind == 1 ? val : int'($urandom_range(4095)));
      a = 1'b0;
      for (int t = 0; t < 1000 && !a; t++)
        step($urandom_range(99) < pv, v, $urandom_range(99) < pr, a);
    end
  endtask

  task automatic drain();
    bit a;
    for (int t = 0; t < 8; t++) step(1'b0, 0, 1'b1, a);
  endtask

  task automatic rand_cfg();
    for (int k = 0; k < 9; k++) io.coeffs[k*CW +: CW] = CW'($urandom_range(255));
    io.shift = SHW'($urandom_range(4));
    io.edge_mode = $urandom_range(1) == 1;
  endtask

  task automatic test_reset();
    bit a;
    @(posedge clk);
    #1;
    n_checks++;
    if ({io.m_valid, io.m_data, io.m_row, io.m_col, io.m_sof} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%0d r=%0d c=%0d sof=%0b, expected all 0", io.m_valid, io.m_data, io.m_row, io.m_col, io.m_sof);
    end
    n_checks++;
    if (io.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_s_ready: got %b expected 1", io.s_ready);
    end
    io.s_valid = 1'b1;
    io.s_data = 12'd7;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (io.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_valid: got %b expected 0", io.m_valid);
    end
    do_reset();
    step(1'b0, 0, 1'b1, a);
    n_checks++;
    if (io.m_valid !== 1'b0 || io.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got m_valid=%b s_ready=%b expected 0/1", io.m_valid, io.s_ready);
    end
  endtask

  task automatic test_identity();
    bit a;
    int first = -1;
    do_reset();
    io.coeffs = '0;
    io.coeffs[4*CW +: CW] = 8'd1;
    io.shift = '0;
    io.edge_mode = 1'b0;
    for (int i = 0; i < 3 * FS; i++) begin
      step(1'b1, i % FS, 1'b1, a);
      if (first < 0 && io.m_valid) begin
        first = i + 1;
        n_checks++;
        if (io.m_data !== 12'd0 || io.m_sof !== 1'b1 || io.m_row !== '0 || io.m_col !== '0) begin
          n_fail++;
          $display("FAIL id_first_pixel: got d=%0d sof=%0b r=%0d c=%0d expected 0 1 0 0", io.m_data, io.m_sof, io.m_row, io.m_col);
        end
      end
    end
    drain();
    n_checks++;
    if (first != COLS + 5) begin
      n_fail++;
      $display("FAIL id_latency: first m_valid after %0d samples, expected %0d", first, COLS + 5);
    end
    n_checks++;
    if (got_q.size() != 3 * FS - COLS - 1) begin
      n_fail++;
      $display("FAIL id_count: got %0d outputs expected %0d", got_q.size(), 3 * FS - COLS - 1);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== DW'(i % FS) || got_q[i].r !== RW'((i % FS) / COLS) || got_q[i].c !== CLW'(i % COLS)) begin
        n_fail++;
        $display("FAIL id_pixel[%0d]: got d=%0d r=%0d c=%0d expected d=%0d r=%0d c=%0d", i, got_q[i].d, got_q[i].r, got_q[i].c, i % FS, (i % FS) / COLS, i % COLS);
      end
      if (i < exp_q.size()) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL id_model[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_edge_mode();
    int e;
    for (int em = 0; em < 2; em++) begin
      do_reset();
      for (int k = 0; k < 9; k++) io.coeffs[k*CW +: CW] = 8'd1;
      io.shift = '0;
      io.edge_mode = em == 1;
      run(2 * FS + COLS + 1, 1, 100, 100, 100);
      drain();
      n_checks++;
      if (got_q.size() != 2 * FS) begin
        n_fail++;
        $display("FAIL edge_count[%0d]: got %0d expected %0d", em, got_q.size(), 2 * FS);
      end
      foreach (got_q[i]) begin
        e = (got_q[i].r == 0 || got_q[i].r == ROWS - 1 || got_q[i].c == 0 || got_q[i].c == COLS - 1) ? (em == 1 ? 0 : 100) : 900;
        n_checks++;
        if (got_q[i].d !== DW'(e)) begin
          n_fail++;
          $display("FAIL edge_pixel[%0d] mode %0d (%0d,%0d): got %0d expected %0d", i, em, got_q[i].r, got_q[i].c, got_q[i].d, e);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int val, e;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      io.coeffs = '0;
      if (t == 0) for (int k = 0; k < 9; k++) io.coeffs[k*CW +: CW] = 8'd1;
      else io.coeffs[4*CW +: CW] = 8'hFF;
      io.shift = '0;
      io.edge_mode = 1'b0;
      val = t == 0 ? 4095 : 50;
      run(FS + COLS + 1, 1, val, 100, 100);
      drain();
      n_checks++;
      if (got_q.size() != FS) begin
        n_fail++;
        $display("FAIL sat_count[%0d]: got %0d expected %0d", t, got_q.size(), FS);
      end
      foreach (got_q[i]) begin
        e = (got_q[i].r == 0 || got_q[i].r == ROWS - 1 || got_q[i].c == 0 || got_q[i].c == COLS - 1) ? val : (t == 0 ? 4095 : 0);
        n_checks++;
        if (got_q[i].d !== DW'(e)) begin
          n_fail++;
          $display("FAIL sat_pixel[%0d] case %0d: got %0d expected %0d", i, t, got_q[i].d, e);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit a;
    int dat[64];
    int i = 0;
    logic [DW-1:0] hd;
    logic [RW-1:0] hr;
    logic [CLW-1:0] hc;
    do_reset();
    rand_cfg();
    foreach (dat[k]) dat[k] = $urandom_range(4095);
    for (int t = 0; t < 200 && i < 13; t++) begin
      step(1'b1, dat[i], 1'b1, a);
      if (a) i++;
    end
    n_checks++;
    if (io.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid_before_stall: got %b expected 1", io.m_valid);
    end
    hd = io.m_data;
    hr = io.m_row;
    hc = io.m_col;
    for (int t = 0; t < 5; t++) begin
      step(1'b1, dat[i], 1'b0, a);
      n_checks++;
      if (io.s_ready !== 1'b0 || a) begin
        n_fail++;
        $display("FAIL bp_s_ready[%0d]: got s_ready=%b accepted=%b expected 0/0", t, io.s_ready, a);
      end
      n_checks++;
      if (io.m_data !== hd || io.m_row !== hr || io.m_col !== hc || io.m_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got d=%0d r=%0d c=%0d v=%b expected d=%0d r=%0d c=%0d v=1", t, io.m_data, io.m_row, io.m_col, io.m_valid, hd, hr, hc);
      end
    end
    for (int t = 0; t < 500 && i < 2 * FS + COLS + 1; t++) begin
      step(1'b1, dat[i], 1'b1, a);
      if (a) i++;
    end
    drain();
    n_checks++;
    if (got_q.size() != 2 * FS || exp_q.size() != 2 * FS) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, model %0d, expected %0d", got_q.size(), exp_q.size(), 2 * FS);
    end
    foreach (got_q[k]) if (k < exp_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL bp_model[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rand_cfg();
      run(3 * FS + COLS + 1, 2, 0, 70, 60);
      drain();
      n_checks++;
      if (got_q.size() != 3 * FS) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: got %0d expected %0d", pass, got_q.size(), 3 * FS);
      end
      foreach (got_q[k]) if (k < exp_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL b2b_model[%0d][%0d]: got %h expected %h", pass, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit a, seen = 1'b0;
    int first = -1;
    do_reset();
    rand_cfg();
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b1, $urandom_range(4095), 1'b1, a);
      seen = io.m_valid && io.m_row == RW'(2) && io.m_col == CLW'(1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid_reach: output (2,1) got not seen, expected seen");
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (io.m_valid !== 1'b0 || io.m_row !== '0 || io.m_col !== '0 || io.m_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%b r=%0d c=%0d d=%0d expected all 0", io.m_valid, io.m_row, io.m_col, io.m_data);
    end
    io.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < FS + COLS + 1; i++) begin
      step(1'b1, $urandom_range(4095), 1'b1, a);
      if (first < 0 && io.m_valid) first = i + 1;
    end
    drain();
    n_checks++;
    if (first != COLS + 5) begin
      n_fail++;
      $display("FAIL rstmid_latency: first m_valid after %0d samples, expected %0d", first, COLS + 5);
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0].r !== '0 || got_q[0].c !== '0 || got_q[0].sof !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_first: got %0d outputs, first %h, expected (0,0) with sof", got_q.size(), got_q.size() ? got_q[0] : '0);
    end
    foreach (got_q[k]) if (k < exp_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL rstmid_model[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_config_change();
    bit a, changed = 1'b0;
    int e, sh1_val;
`ifdef CONV3X3_ROUND_EN
    sh1_val = 4;
`else
    sh1_val = 3;
`endif
    do_reset();
    io.coeffs = '0;
    io.coeffs[4*CW +: CW] = 8'd7;
    io.shift = '0;
    io.edge_mode = 1'b0;
    for (int i = 0; i < 2 * FS + COLS + 1; i++) begin
      step(1'b1, 1, 1'b1, a);
      if (!changed && io.m_valid && io.m_row == RW'(1) && io.m_col == CLW'(2)) begin
        io.shift = SHW'(1);
        changed = 1'b1;
      end
    end
    drain();
    n_checks++;
    if (!changed || got_q.size() != 2 * FS) begin
      n_fail++;
      $display("FAIL cfg_count: got changed=%0b outputs=%0d expected 1 and %0d", changed, got_q.size(), 2 * FS);
    end
    foreach (got_q[k]) begin
      e = (got_q[k].r == 0 || got_q[k].r == ROWS - 1 || got_q[k].c == 0 || got_q[k].c == COLS - 1) ? 1 : (k < FS ? 7 : sh1_val);
      n_checks++;
      if (got_q[k].d !== DW'(e)) begin
        n_fail++;
        $display("FAIL cfg_pixel[%0d] (%0d,%0d): got %0d expected %0d", k, got_q[k].r, got_q[k].c, got_q[k].d, e);
      end
      if (k < exp_q.size()) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL cfg_model[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    io.s_valid = 1'b0;
    io.s_data = '0;
    io.m_ready = 1'b1;
    io.coeffs = '0;
    io.shift = '0;
    io.edge_mode = 1'b0;
    clear_model();
    test_reset();
    test_identity();
    test_edge_mode();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_config_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
